// File: rtl/axi_lite_master_read.sv
// AXI4-Lite read initiator: one outstanding read, user command/response port on one side,
// AR/R channels on the other. Define AXIL_MASTER_RD_TIMEOUT_EN to add the DATA-state watchdog.
module axi_lite_master_read #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  M_AXIL_ACLK,
   input  logic                  M_AXIL_ARESET,
   input  logic                  user_port_cmd_valid,
   output logic                  user_port_cmd_ready,
   input  logic [ADDR_WIDTH-1:0] user_port_cmd_addr,
   input  logic [2:0]            user_port_cmd_prot,
   output logic                  user_port_rsp_valid,
   input  logic                  user_port_rsp_ready,
   output logic [DATA_WIDTH-1:0] user_port_rsp_data,
   output logic [1:0]            user_port_rsp_resp,
   output logic                  M_AXIL_ARVALID,
   input  logic                  M_AXIL_ARREADY,
   output logic [ADDR_WIDTH-1:0] M_AXIL_ARADDR,
   output logic [2:0]            M_AXIL_ARPROT,
   input  logic                  M_AXIL_RVALID,
   output logic                  M_AXIL_RREADY,
   input  logic [DATA_WIDTH-1:0] M_AXIL_RDATA,
   input  logic [1:0]            M_AXIL_RRESP,
   output logic                  timeout_err
);

   localparam int unsigned LSB = $clog2(DATA_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((64'd1 << LSB) - 64'd1);

`ifdef AXIL_MASTER_RD_TIMEOUT_EN
   typedef enum logic [2:0] {StIdle, StAddr, StData, StResp, StDrain} state_e;
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] cnt_q;
   logic             timed_out_q;
`else
   typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;
   assign timeout_err = 1'b0;
`endif

   state_e state_q;

   always_ff @(posedge M_AXIL_ACLK or posedge M_AXIL_ARESET) begin
      if (M_AXIL_ARESET) begin
         state_q             <= StIdle;
         user_port_cmd_ready <= 1'b0;
         user_port_rsp_valid <= 1'b0;
         user_port_rsp_data  <= '0;
         user_port_rsp_resp  <= 2'b00;
         M_AXIL_ARVALID      <= 1'b0;
         M_AXIL_ARADDR       <= '0;
         M_AXIL_ARPROT       <= 3'b000;
         M_AXIL_RREADY       <= 1'b0;
`ifdef AXIL_MASTER_RD_TIMEOUT_EN
         cnt_q               <= '0;
         timed_out_q         <= 1'b0;
         timeout_err         <= 1'b0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (user_port_cmd_valid && user_port_cmd_ready) begin
                  user_port_cmd_ready <= 1'b0;
                  M_AXIL_ARADDR       <= user_port_cmd_addr & ADDR_MASK;
                  M_AXIL_ARPROT       <= user_port_cmd_prot;
                  M_AXIL_ARVALID      <= 1'b1;
                  state_q             <= StAddr;
               end else begin
                  user_port_cmd_ready <= 1'b1;
               end
            end
            StAddr: begin
               if (M_AXIL_ARREADY) begin
                  M_AXIL_ARVALID <= 1'b0;
                  M_AXIL_RREADY  <= 1'b1;
                  state_q        <= StData;
`ifdef AXIL_MASTER_RD_TIMEOUT_EN
                  cnt_q          <= '0;
`endif
               end
            end
            StData: begin
               // Real data beats the watchdog when both land in the same cycle.
               if (M_AXIL_RVALID && M_AXIL_RREADY) begin
                  M_AXIL_RREADY       <= 1'b0;
                  user_port_rsp_data  <= M_AXIL_RDATA;
                  user_port_rsp_resp  <= M_AXIL_RRESP;
                  user_port_rsp_valid <= 1'b1;
                  state_q             <= StResp;
               end
`ifdef AXIL_MASTER_RD_TIMEOUT_EN
               else if (cnt_q == CNT_LAST) begin
                  M_AXIL_RREADY       <= 1'b0;
                  user_port_rsp_data  <= '0;
                  user_port_rsp_resp  <= 2'b10;
                  user_port_rsp_valid <= 1'b1;
                  timeout_err         <= 1'b1;
                  timed_out_q         <= 1'b1;
                  state_q             <= StResp;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
`endif
            end
            StResp: begin
               if (user_port_rsp_ready) begin
                  user_port_rsp_valid <= 1'b0;
`ifdef AXIL_MASTER_RD_TIMEOUT_EN
                  if (timed_out_q) begin
                     // The slave still owes a beat; swallow it before taking new work.
                     timed_out_q   <= 1'b0;
                     M_AXIL_RREADY <= 1'b1;
                     state_q       <= StDrain;
                  end else begin
                     user_port_cmd_ready <= 1'b1;
                     state_q             <= StIdle;
                  end
`else
                  user_port_cmd_ready <= 1'b1;
                  state_q             <= StIdle;
`endif
               end
            end
`ifdef AXIL_MASTER_RD_TIMEOUT_EN
            StDrain: begin
               if (M_AXIL_RVALID) begin
                  M_AXIL_RREADY       <= 1'b0;
                  user_port_cmd_ready <= 1'b1;
                  state_q             <= StIdle;
               end
            end
`endif
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_master_read.sv
// Self-checking bench for axi_lite_master_read: randomized slave delays and data checked
// against expected address alignment, passthrough data and cycle timing.
module tb_axi_lite_master_read;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic [2:0]    cmd_prot = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_data;
   logic [1:0]    rsp_resp;
   logic          arvalid;
   logic          arready;
   logic [AW-1:0] araddr;
   logic [2:0]    arprot;
   logic          rvalid;
   logic          rready;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;
   logic          timeout_err;

   always #5 clk = ~clk;

   axi_lite_master_read #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .M_AXIL_ACLK        (clk),
      .M_AXIL_ARESET      (rst),
      .user_port_cmd_valid(cmd_valid),
      .user_port_cmd_ready(cmd_ready),
      .user_port_cmd_addr (cmd_addr),
      .user_port_cmd_prot (cmd_prot),
      .user_port_rsp_valid(rsp_valid),
      .user_port_rsp_ready(rsp_ready),
      .user_port_rsp_data (rsp_data),
      .user_port_rsp_resp (rsp_resp),
      .M_AXIL_ARVALID     (arvalid),
      .M_AXIL_ARREADY     (arready),
      .M_AXIL_ARADDR      (araddr),
      .M_AXIL_ARPROT      (arprot),
      .M_AXIL_RVALID      (rvalid),
      .M_AXIL_RREADY      (rready),
      .M_AXIL_RDATA       (rdata),
      .M_AXIL_RRESP       (rresp),
      .timeout_err        (timeout_err)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave model configuration and observation
   int          ar_delay = 0;
   int          r_delay = 0;
   bit          slv_silent = 1'b0;
   logic [31:0] slv_data_q[$];
   logic [1:0]  slv_resp_q[$];
   logic [31:0] ar_addr_log[$];
   logic [2:0]  ar_prot_log[$];
   int          ar_unstable = 0;
   int          r_beats = 0;

   // Slave: drives on negedges, so the DUT samples stable inputs at each posedge.
   initial begin : slave
      int          ar_cnt;
      int          r_cnt;
      int          r_owed;
      bit          ar_active;
      bit          r_hs_pend;
      logic [31:0] held_addr;
      logic [2:0]  held_prot;
      ar_cnt = 0; r_cnt = 0; r_owed = 0; ar_active = 0; r_hs_pend = 0;
      held_addr = '0; held_prot = '0;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            arready = 1'b0; rvalid = 1'b0;
            ar_cnt = 0; r_cnt = 0; r_owed = 0; ar_active = 0; r_hs_pend = 0;
         end else begin
            if (r_hs_pend) begin
               rvalid = 1'b0;
               r_hs_pend = 1'b0;
            end
            if (!rvalid && r_owed > 0 && !slv_silent) begin
               if (r_cnt >= r_delay) begin
                  rvalid = 1'b1;
                  rdata  = (slv_data_q.size() > 0) ? slv_data_q.pop_front() : 32'h0;
                  rresp  = (slv_resp_q.size() > 0) ? slv_resp_q.pop_front() : 2'b00;
                  r_owed--;
                  r_cnt = 0;
               end else begin
                  r_cnt++;
               end
            end
            r_hs_pend = rvalid && rready;
            if (r_hs_pend) r_beats++;
            if (arvalid) begin
               if (!ar_active) begin
                  ar_active = 1'b1;
                  held_addr = araddr;
                  held_prot = arprot;
               end else if (araddr !== held_addr || arprot !== held_prot) begin
                  ar_unstable++;
               end
               arready = (ar_cnt >= ar_delay);
               ar_cnt++;
               if (arready) begin
                  ar_addr_log.push_back(araddr);
                  ar_prot_log.push_back(arprot);
                  r_owed++;
                  ar_active = 1'b0;
                  ar_cnt = 0;
               end
            end else begin
               if (ar_active) ar_unstable++;
               ar_active = 1'b0;
               arready = 1'b0;
               ar_cnt = 0;
            end
         end
      end
   end

   // Holds cmd_valid until accepted; t_hs is the index of the accepting clock edge.
   task automatic issue_cmd(input logic [31:0] addr, input logic [2:0] prot,
                            output int t_hs, output bit ok);
      ok = 1'b0;
      t_hs = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_addr = addr;
      cmd_prot = prot;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (i > 0) @(negedge clk);
         if (cmd_ready) begin
            @(posedge clk);
            #1;
            t_hs = cyc;
            ok = 1'b1;
         end
      end
      cmd_valid = 1'b0;
   endtask

   // ready_delay 0 holds rsp_ready high in advance; t_done is the completing clock edge.
   task automatic get_rsp(input int ready_delay, output logic [31:0] data,
                          output logic [1:0] resp, output int t_done, output bit ok,
                          output bit stable, output bit busy_ready);
      ok = 1'b0; stable = 1'b1; busy_ready = 1'b0; t_done = 0; data = '0; resp = '0;
      rsp_ready = (ready_delay == 0);
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (rsp_valid) ok = 1'b1;
         else if (cmd_ready) busy_ready = 1'b1;
      end
      if (ok) begin
         data = rsp_data;
         resp = rsp_resp;
         for (int i = 0; i < ready_delay; i++) begin
            if (cmd_ready) busy_ready = 1'b1;
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== data || rsp_resp !== resp) stable = 1'b0;
         end
         rsp_ready = 1'b1;
         @(posedge clk);
         #1;
         t_done = cyc;
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      vectors++;
      if ({cmd_ready, rsp_valid, arvalid, rready, timeout_err} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b expected 00000",
                  {cmd_ready, rsp_valid, arvalid, rready, timeout_err});
      end
      vectors++;
      if ({rsp_data, rsp_resp, araddr, arprot} !== '0) begin
         miscompares++;
         $display("FAIL reset_data: got %h/%h/%h/%h expected all zero",
                  rsp_data, rsp_resp, araddr, arprot);
      end
      #1 rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release_cmd_ready: got %b expected 1", cmd_ready);
      end
   endtask

   task automatic test_basic;
      int t_hs, t_done; bit ok, stable, busy; logic [31:0] d; logic [1:0] r;
      ar_addr_log.delete(); ar_prot_log.delete();
      ar_delay = 0; r_delay = 0;
      slv_data_q.push_back(32'hDEADBEEF); slv_resp_q.push_back(2'b00);
      issue_cmd(32'h1000_0004, 3'b010, t_hs, ok);
      get_rsp(0, d, r, t_done, ok, stable, busy);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL basic_done: got no response expected one"); end
      vectors++;
      if (ar_addr_log.size() == 0 || ar_addr_log[0] !== 32'h1000_0004) begin
         miscompares++;
         $display("FAIL basic_araddr: got %h expected 10000004",
                  ar_addr_log.size() ? ar_addr_log[0] : 32'hx);
      end
      vectors++;
      if (ar_prot_log.size() == 0 || ar_prot_log[0] !== 3'b010) begin
         miscompares++; $display("FAIL basic_arprot: expected 010 on the bus");
      end
      vectors++;
      if (d !== 32'hDEADBEEF || r !== 2'b00) begin
         miscompares++; $display("FAIL basic_data: got %h/%b expected deadbeef/00", d, r);
      end
      vectors++;
      if (t_done - t_hs !== 3) begin
         miscompares++; $display("FAIL basic_latency: got %0d expected 3", t_done - t_hs);
      end
   endtask

   task automatic test_misaligned_backpressure;
      int t_hs, t_done, unst0, beats0; bit ok, stable, busy, extra; logic [31:0] d;
      logic [1:0] r;
      ar_addr_log.delete(); ar_prot_log.delete();
      unst0 = ar_unstable; beats0 = r_beats;
      ar_delay = 4; r_delay = 0;
      slv_data_q.push_back(32'h0BADF00D); slv_resp_q.push_back(2'b01);
      issue_cmd(32'h0000_0023, 3'b101, t_hs, ok);
      get_rsp(3, d, r, t_done, ok, stable, busy);
      extra = 1'b0;
      repeat (4) begin @(negedge clk); if (rsp_valid) extra = 1'b1; end
      vectors++;
      if (ar_addr_log.size() != 1 || ar_addr_log[0] !== 32'h20) begin
         miscompares++; $display("FAIL mis_araddr: got %0d beats expected one at 20",
                                 ar_addr_log.size());
      end
      vectors++;
      if (ar_unstable != unst0) begin
         miscompares++; $display("FAIL mis_ar_stable: got %0d glitches expected 0",
                                 ar_unstable - unst0);
      end
      vectors++;
      if (!ok || !stable || d !== 32'h0BADF00D || r !== 2'b01) begin
         miscompares++; $display("FAIL mis_rsp: got %h/%b stable=%b expected 0badf00d/01 stable",
                                 d, r, stable);
      end
      vectors++;
      if (busy) begin miscompares++; $display("FAIL mis_cmd_ready: got 1 while busy expected 0"); end
      vectors++;
      if (extra || r_beats - beats0 != 1) begin
         miscompares++; $display("FAIL mis_single: got extra=%b beats=%0d expected 0/1",
                                 extra, r_beats - beats0);
      end
      ar_delay = 0;
   endtask

   task automatic test_error;
      int t_hs, t_done; bit ok, stable, busy; logic [31:0] d; logic [1:0] r;
      ar_addr_log.delete(); ar_prot_log.delete();
      slv_data_q.push_back(32'h5A5A5A5A); slv_resp_q.push_back(2'b11);
      issue_cmd(32'h0000_0040, 3'b000, t_hs, ok);
      get_rsp(1, d, r, t_done, ok, stable, busy);
      vectors++;
      if (!ok || d !== 32'h5A5A5A5A || r !== 2'b11) begin
         miscompares++; $display("FAIL err_passthru: got %h/%b expected 5a5a5a5a/11", d, r);
      end
      vectors++;
      if (timeout_err !== 1'b0) begin
         miscompares++; $display("FAIL err_timeout_flag: got %b expected 0", timeout_err);
      end
   endtask

   task automatic test_reset_mid_data;
      int t_hs, t_done; bit ok, stable, busy; logic [31:0] d; logic [1:0] r;
      ar_addr_log.delete(); ar_prot_log.delete();
      r_delay = 20;
      slv_data_q.push_back(32'h11111111); slv_resp_q.push_back(2'b00);
      issue_cmd(32'h0000_0ABC, 3'b111, t_hs, ok);
      while (cyc < t_hs + 3) @(negedge clk);
      vectors++;
      if (rready !== 1'b1) begin miscompares++; $display("FAIL rst_pre_rready: got %b expected 1", rready); end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({cmd_ready, rsp_valid, arvalid, rready, timeout_err} !== 5'b0 ||
          {rsp_data, rsp_resp, araddr, arprot} !== '0) begin
         miscompares++;
         $display("FAIL rst_async: got ctrl=%b addr=%h prot=%b expected all zero",
                  {cmd_ready, rsp_valid, arvalid, rready, timeout_err}, araddr, arprot);
      end
      repeat (2) @(negedge clk);
      slv_data_q.delete(); slv_resp_q.delete(); ar_addr_log.delete(); ar_prot_log.delete();
      r_delay = 0;
      #1 rst = 1'b0;
      slv_data_q.push_back(32'hCAFEF00D); slv_resp_q.push_back(2'b00);
      issue_cmd(32'h0000_0200, 3'b001, t_hs, ok);
      get_rsp(0, d, r, t_done, ok, stable, busy);
      vectors++;
      if (!ok || d !== 32'hCAFEF00D || r !== 2'b00 || t_done - t_hs !== 3) begin
         miscompares++; $display("FAIL rst_recover: got %h/%b lat=%0d expected cafef00d/00 lat=3",
                                 d, r, t_done - t_hs);
      end
   endtask

   task automatic test_back_to_back;
      int hs[4]; int done[4]; logic [31:0] d[4]; logic [1:0] r[4]; bit okc[4]; bit okr[4];
      ar_addr_log.delete(); ar_prot_log.delete();
      ar_delay = 0; r_delay = 0;
      for (int i = 0; i < 4; i++) begin
         slv_data_q.push_back(32'hB0B0_0000 + 32'(i)); slv_resp_q.push_back(2'(i));
      end
      fork
         begin
            for (int i = 0; i < 4; i++) issue_cmd(32'h3000_0000 + 32'(i * 4), 3'b000, hs[i], okc[i]);
         end
         begin
            bit st, bz;
            for (int j = 0; j < 4; j++) get_rsp(0, d[j], r[j], done[j], okr[j], st, bz);
         end
      join
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (!okc[i] || !okr[i] || d[i] !== 32'hB0B0_0000 + 32'(i) || r[i] !== 2'(i)) begin
            miscompares++; $display("FAIL b2b_rsp%0d: got %h/%b expected %h/%b",
                                    i, d[i], r[i], 32'hB0B0_0000 + 32'(i), 2'(i));
         end
         vectors++;
         if (ar_addr_log.size() <= i || ar_addr_log[i] !== 32'h3000_0000 + 32'(i * 4)) begin
            miscompares++; $display("FAIL b2b_araddr%0d: wrong or missing AR beat", i);
         end
      end
      // Accepted at T, response completes at T+3, next accept at T+4.
      for (int i = 1; i < 4; i++) begin
         vectors++;
         if (hs[i] - hs[i-1] !== 4) begin
            miscompares++; $display("FAIL b2b_interval%0d: got %0d expected 4", i, hs[i] - hs[i-1]);
         end
      end
   endtask

   task automatic test_random;
      int t_hs, t_done; bit ok, stable, busy; logic [31:0] d, a, exp_d; logic [1:0] r, exp_r;
      logic [2:0] p;
      for (int n = 0; n < 16; n++) begin
         ar_addr_log.delete(); ar_prot_log.delete();
         a = $urandom; p = 3'($urandom); exp_d = $urandom; exp_r = 2'($urandom);
         ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
         slv_data_q.push_back(exp_d); slv_resp_q.push_back(exp_r);
         issue_cmd(a, p, t_hs, ok);
         get_rsp($urandom_range(0, 3), d, r, t_done, ok, stable, busy);
         vectors++;
         if (ar_addr_log.size() != 1 || ar_addr_log[0] !== {a[31:2], 2'b00} ||
             ar_prot_log[0] !== p) begin
            miscompares++; $display("FAIL rnd_ar%0d: addr %h prot %b expected aligned beat", n, a, p);
         end
         vectors++;
         if (!ok || !stable || busy || d !== exp_d || r !== exp_r) begin
            miscompares++; $display("FAIL rnd_rsp%0d: got %h/%b expected %h/%b", n, d, r, exp_d, exp_r);
         end
      end
      ar_delay = 0; r_delay = 0;
   endtask

`ifdef AXIL_MASTER_RD_TIMEOUT_EN
   task automatic test_timeout;
      int t_hs, t_done, beats0; bit ok, stable, busy, seen; logic [31:0] d; logic [1:0] r;
      ar_addr_log.delete(); ar_prot_log.delete();
      slv_silent = 1'b1; ar_delay = 0; r_delay = 0;
      issue_cmd(32'h0000_0100, 3'b000, t_hs, ok);
      get_rsp(0, d, r, t_done, ok, stable, busy);
      vectors++;
      if (!ok || r !== 2'b10 || d !== 32'h0 || t_done - t_hs !== 10) begin
         miscompares++; $display("FAIL to_rsp: got %h/%b lat=%0d expected 0/10 lat=10",
                                 d, r, t_done - t_hs);
      end
      vectors++;
      if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL to_flag: got %b expected 1", timeout_err); end
      @(negedge clk);
      vectors++;
      if (rready !== 1'b1 || cmd_ready !== 1'b0) begin
         miscompares++; $display("FAIL to_drain: got rready=%b cmd_ready=%b expected 1/0", rready, cmd_ready);
      end
      beats0 = r_beats;
      slv_data_q.push_back(32'hBAD0BAD0); slv_resp_q.push_back(2'b00);
      slv_silent = 1'b0;
      seen = 1'b0;
      repeat (8) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
      vectors++;
      if (seen || r_beats - beats0 != 1 || cmd_ready !== 1'b1) begin
         miscompares++; $display("FAIL to_absorb: got rsp=%b beats=%0d cmd_ready=%b expected 0/1/1",
                                 seen, r_beats - beats0, cmd_ready);
      end
      slv_data_q.push_back(32'h13572468); slv_resp_q.push_back(2'b00);
      issue_cmd(32'h0000_0104, 3'b000, t_hs, ok);
      get_rsp(0, d, r, t_done, ok, stable, busy);
      vectors++;
      if (!ok || d !== 32'h13572468 || r !== 2'b00 || timeout_err !== 1'b1) begin
         miscompares++; $display("FAIL to_next: got %h/%b err=%b expected 13572468/00 err=1",
                                 d, r, timeout_err);
      end
   endtask
`endif

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_misaligned_backpressure();
      test_error();
      test_reset_mid_data();
      test_back_to_back();
      test_random();
`ifdef AXIL_MASTER_RD_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
